// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: filtered clock, 11-bit deserialiser,
// parity/stop checking and an inter-edge watchdog. Listens only.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000,
    parameter int TO_W       = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic       rx_idle,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DPS,
        S_LOAD
    } state_t;

    state_t                  state;
    logic [1:0]              d_sync;
    logic                    d_s;
    logic [FILTER_LEN-1:0]   filter_reg;
    logic                    f_ps2c_reg;
    logic                    f_ps2c_next;
    logic                    fall_edge;
    logic [3:0]              n;
    logic [10:0]             b;
    logic [10:0]             b_next;
    logic [TO_W-1:0]         to_cnt;

    assign d_s = d_sync[1];

    // The level only flips after FILTER_LEN identical samples, so short
    // glitches on the open-collector clock never produce an edge.
    always_comb begin
        f_ps2c_next = f_ps2c_reg;
        if (&filter_reg)
            f_ps2c_next = 1'b1;
        else if (~|filter_reg)
            f_ps2c_next = 1'b0;
    end

    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;
    assign b_next    = {d_s, b[10:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            d_sync     <= 2'b11;
            filter_reg <= '1;
            f_ps2c_reg <= 1'b1;
        end else begin
            d_sync     <= {d_sync[0], ps2d};
            filter_reg <= {ps2c, filter_reg[FILTER_LEN-1:1]};
            f_ps2c_reg <= f_ps2c_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rx_idle      <= 1'b1;
            rx_done_tick <= 1'b0;
            timeout_tick <= 1'b0;
            dout         <= 8'h00;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            n            <= 4'd0;
            b            <= 11'd0;
            to_cnt       <= '0;
        end else begin
            rx_done_tick <= 1'b0;
            timeout_tick <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (fall_edge && rx_en && !d_s) begin
                        b       <= b_next;
                        n       <= 4'd9;
                        to_cnt  <= '0;
                        state   <= S_DPS;
                        rx_idle <= 1'b0;
                    end
                end
                S_DPS: begin
                    if (!rx_en) begin
                        state   <= S_IDLE;
                        rx_idle <= 1'b1;
                    end else if (fall_edge) begin
                        b      <= b_next;
                        to_cnt <= '0;
                        if (n == 4'd0) begin
                            state        <= S_LOAD;
                            rx_done_tick <= 1'b1;
                            dout         <= b_next[8:1];
                            parity_err   <= ~^b_next[9:1];
                            frame_err    <= ~b_next[10];
                        end else begin
                            n <= n - 4'd1;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        state        <= S_IDLE;
                        rx_idle      <= 1'b1;
                        timeout_tick <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    state   <= S_IDLE;
                    rx_idle <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    rx_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, parity/stop errors, watchdog,
// glitch rejection, receive enable and mid-frame reset.
module tb_ps2_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rx_idle;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_tick;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int tmo_cnt = 0;

    ps2_rx #(
        .FILTER_LEN(8),
        .TIMEOUT(1000),
        .TO_W(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_en(rx_en),
        .ps2d(ps2d),
        .ps2c(ps2c),
        .rx_idle(rx_idle),
        .rx_done_tick(rx_done_tick),
        .dout(dout),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .timeout_tick(timeout_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done_tick) done_cnt++;
        if (timeout_tick) tmo_cnt++;
    end

    task automatic wait_clks(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Data set up in the high phase, then clock driven low.
    task automatic bit_start(input logic v);
        ps2d = v;
        wait_clks(100);
        ps2c = 1'b0;
    endtask

    task automatic bit_finish();
        wait_clks(200);
        ps2c = 1'b1;
        wait_clks(100);
    endtask

    task automatic send_bits(input logic [10:0] f, input int nb, input int glitch_at);
        for (int i = 0; i < nb; i++) begin
            bit_start(f[i]);
            bit_finish();
            if (i == glitch_at) begin
                ps2c = 1'b0;
                wait_clks(5);
                ps2c = 1'b1;
                wait_clks(50);
            end
        end
        ps2d = 1'b1;
    endtask

    task automatic test_reset();
        wait_clks(4);
        reset = 1'b0;
        wait_clks(2);
        checks++;
        if (rx_idle !== 1'b1) begin
            errors++; $display("FAIL reset_idle got %b want 1", rx_idle);
        end
        checks++;
        if (dout !== 8'h00 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs got %h/%b/%b want 00/0/0", dout, parity_err, frame_err);
        end
        checks++;
        if (rx_done_tick !== 1'b0 || timeout_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_ticks got %b/%b want 0/0", rx_done_tick, timeout_tick);
        end
    endtask

    task automatic test_basic();
        logic [10:0] f = {1'b1, 1'b1, 8'hA5, 1'b0};
        int d0 = done_cnt;
        int k = 0;
        send_bits(f, 10, -1);
        bit_start(f[10]);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            k = i;
            if (rx_done_tick) break;
        end
        checks++;
        if (k !== 9) begin
            errors++; $display("FAIL basic_latency got %0d want 9", k);
        end
        checks++;
        if (dout !== 8'hA5 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_data got %h/%b/%b want a5/0/0", dout, parity_err, frame_err);
        end
        @(negedge clk);
        checks++;
        if (rx_idle !== 1'b1 || rx_done_tick !== 1'b0) begin
            errors++;
            $display("FAIL basic_after got idle %b tick %b want 1/0", rx_idle, rx_done_tick);
        end
        bit_finish();
        ps2d = 1'b1;
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL basic_count got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_parity();
        int d0 = done_cnt;
        send_bits({1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1);
        checks++;
        if (dout !== 8'h3C || parity_err !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad got %h/%b/%b want 3c/1/0", dout, parity_err, frame_err);
        end
        send_bits({1'b1, 1'b1, 8'h00, 1'b0}, 11, -1);
        checks++;
        if (dout !== 8'h00 || parity_err !== 1'b0 || done_cnt - d0 !== 2) begin
            errors++;
            $display("FAIL parity_clear got %h/%b cnt %0d want 00/0 cnt 2", dout, parity_err, done_cnt - d0);
        end
    endtask

    task automatic test_frame_err();
        int d0 = done_cnt;
        send_bits({1'b0, 1'b1, 8'h81, 1'b0}, 11, -1);
        checks++;
        if (dout !== 8'h81 || parity_err !== 1'b0 || frame_err !== 1'b1 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL frame_err got %h/%b/%b cnt %0d want 81/0/1 cnt 1", dout, parity_err, frame_err, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] f = {1'b1, 1'b0, 8'h77, 1'b0};
        int d0 = done_cnt;
        int k = 0;
        send_bits(f, 4, -1);
        bit_start(f[4]);
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            k = i;
            if (timeout_tick) break;
            if (i == 200) begin
                ps2c = 1'b1;
                ps2d = 1'b1;
            end
        end
        checks++;
        if (k !== 1009) begin
            errors++; $display("FAIL timeout_delay got %0d want 1009", k);
        end
        @(negedge clk);
        checks++;
        if (timeout_tick !== 1'b0 || rx_idle !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after got tick %b idle %b want 0/1", timeout_tick, rx_idle);
        end
        checks++;
        if (done_cnt - d0 !== 0 || dout !== 8'h81 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold got cnt %0d %h/%b want 0 81/1", done_cnt - d0, dout, frame_err);
        end
        wait_clks(50);
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 11, -1);
        checks++;
        if (dout !== 8'h5A || parity_err !== 1'b0 || frame_err !== 1'b0 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL timeout_recover got %h/%b/%b cnt %0d want 5a/0/0 cnt 1", dout, parity_err, frame_err, done_cnt - d0);
        end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        ps2c = 1'b0;
        wait_clks(5);
        ps2c = 1'b1;
        wait_clks(30);
        checks++;
        if (rx_idle !== 1'b1 || done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL glitch_idle got idle %b cnt %0d want 1/0", rx_idle, done_cnt - d0);
        end
        send_bits({1'b1, 1'b1, 8'h12, 1'b0}, 11, 3);
        checks++;
        if (dout !== 8'h12 || parity_err !== 1'b0 || frame_err !== 1'b0 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL glitch_frame got %h/%b/%b cnt %0d want 12/0/0 cnt 1", dout, parity_err, frame_err, done_cnt - d0);
        end
    endtask

    task automatic test_rx_en();
        int d0 = done_cnt;
        int t0 = tmo_cnt;
        rx_en = 1'b0;
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 11, -1);
        checks++;
        if (done_cnt - d0 !== 0 || dout !== 8'h12 || rx_idle !== 1'b1) begin
            errors++;
            $display("FAIL rxen_off got cnt %0d %h idle %b want 0 12 1", done_cnt - d0, dout, rx_idle);
        end
        rx_en = 1'b1;
        wait_clks(20);
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 3, -1);
        checks++;
        if (rx_idle !== 1'b0) begin
            errors++; $display("FAIL rxen_busy got idle %b want 0", rx_idle);
        end
        rx_en = 1'b0;
        wait_clks(3);
        checks++;
        if (rx_idle !== 1'b1) begin
            errors++; $display("FAIL rxen_drop got idle %b want 1", rx_idle);
        end
        wait_clks(1200);
        rx_en = 1'b1;
        checks++;
        if (done_cnt - d0 !== 0 || tmo_cnt - t0 !== 0 || dout !== 8'h12) begin
            errors++;
            $display("FAIL rxen_quiet got done %0d tmo %0d %h want 0 0 12", done_cnt - d0, tmo_cnt - t0, dout);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        send_bits({1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1);
        send_bits({1'b1, 1'b1, 8'h66, 1'b0}, 5, -1);
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(2);
        checks++;
        if (rx_idle !== 1'b1 || dout !== 8'h00 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset got idle %b %h/%b/%b want 1 00/0/0", rx_idle, dout, parity_err, frame_err);
        end
        wait_clks(20);
        send_bits({1'b1, 1'b1, 8'hFF, 1'b0}, 11, -1);
        checks++;
        if (dout !== 8'hFF || parity_err !== 1'b0 || frame_err !== 1'b0 || done_cnt - d0 !== 2) begin
            errors++;
            $display("FAIL midreset_next got %h/%b/%b cnt %0d want ff/0/0 cnt 2", dout, parity_err, frame_err, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        wait_clks(20);
        test_basic();
        test_parity();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_rx_en();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
